// File: rtl/derot_pkg.sv
// derot_pkg: shared states, direction encoding and default sizes for seq_derotator
package derot_pkg;
  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;
  localparam logic DIR_LEFT = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;
  localparam int WIDTH_D = 8;
  localparam int AMT_W_D = 3;
endpackage

// File: rtl/rot_step.sv
// rot_step: combinational rotate of a word by a (one-hot) step in a given direction
module rot_step #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] step,
  input  logic             left,
  output logic [WIDTH-1:0] result
);
  logic [2*WIDTH-1:0] dd;
  logic [AMT_W-1:0] amt;
  assign dd = {data, data};
  // a left rotate by s is a right rotate by (WIDTH - s) mod WIDTH
  assign amt = left ? '0 - step : step;
  assign result = WIDTH'(dd >> amt);
endmodule

// File: rtl/seq_derotator.sv
// seq_derotator: multi-cycle inverse of the barrel rotator over valid/ready.
// DEROT_LOG_STEP_EN: step by the highest set bit of count instead of by one.
module seq_derotator
  import derot_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int AMT_W = AMT_W_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_lr,
  input  logic [AMT_W-1:0] in_amount,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  state_t state, state_nxt;
  logic [WIDTH-1:0] shreg, rotated, out_q;
  logic [AMT_W-1:0] count, step, count_nxt;
  logic dir;
  rot_step #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_step (
    .data(shreg),
    .step(step),
    .left(dir == DIR_RIGHT),
    .result(rotated)
  );
`ifdef DEROT_LOG_STEP_EN
  always_comb begin
    step = '0;
    for (int i = 0; i < AMT_W; i++)
      if (count[i]) step = AMT_W'(1) << i;
  end
`else
  assign step = AMT_W'(1);
`endif
  assign count_nxt = count - step;
  assign in_ready = (state == IDLE) && rst_n;
  assign busy = state != IDLE;
  assign out_valid = state == DONE;
  assign out_data = out_q;
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: state_nxt = in_valid ? (in_amount == '0 ? DONE : ROTATE) : IDLE;
      ROTATE: state_nxt = count_nxt == '0 ? DONE : ROTATE;
      DONE: state_nxt = out_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      count <= '0;
      out_q <= '0;
      dir <= DIR_RIGHT;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        shreg <= in_data;
        dir <= in_lr;
        count <= in_amount;
        if (in_amount == '0) out_q <= in_data;
      end else if (state == ROTATE) begin
        shreg <= rotated;
        count <= count_nxt;
        if (count_nxt == '0) out_q <= rotated;
      end
    end
  end
endmodule

// File: doc/seq_derotator.md
Name: seq_derotator

Overview:
- Multi-cycle inverse of the combinational 8-bit barrel rotator.
- Accepts a rotated word tagged with its original direction (lr) and amount. Undoes the rotation by stepping in the opposite direction, one position per clock. Returns the restored word over a valid/ready handshake.
- Sits downstream of the rotator; used to recover the original data and to cross-check the rotator in system tests.

Parameters:
- WIDTH, 8, data word width in bits.
- AMT_W, 3, width of the amount field; must equal clog2(WIDTH).

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  input word and tags are valid.
- in_ready  output  1  block can accept a job.
- in_data  input  WIDTH  rotated word.
- in_lr  input  1  original direction: 1 = word was left-rotated, 0 = right-rotated.
- in_amount  input  AMT_W  original rotate amount.
- out_valid  output  1  restored word available.
- out_ready  input  1  consumer accepts the word.
- out_data  output  WIDTH  restored word.
- busy  output  1  job in progress (state != IDLE).

Behaviour:
- Reset: while rst_n=0 at a rising edge, state<=IDLE, shift register<=0, count<=0.
  - out_valid=0, out_data=0, busy=0.
  - in_ready is held 0 while rst_n=0.
- States: IDLE, ROTATE, DONE. in_ready = (state==IDLE) && rst_n.
- IDLE: on in_valid && in_ready, load shreg<=in_data, dir<=in_lr, count<=in_amount.
  - Next state is DONE if in_amount==0, otherwise ROTATE.
- ROTATE: each cycle rotate shreg by 1 opposite to dir (dir=1 -> rotate right; dir=0 -> rotate left) and decrement count.
  - When count==1 at the edge, go to DONE.
- DONE: out_valid=1 and out_data=shreg, held stable.
  - On out_ready=1, go to IDLE.
  - No new job is accepted in the same cycle. The next accept is possible in the following cycle.
- Latency: accept edge to first cycle with out_valid=1 is max(amount,1)+... defined precisely as:
  - 1 edge for amount=0;
  - amount+1 edges for amount>0.
  - Example: amount=3 gives out_valid in the 4th cycle after the accept cycle.
- out_data is registered and changes only on the ROTATE->DONE or IDLE->DONE transition. It holds its last value in IDLE and does not return to 0.
- Boundary conditions:
  - in_valid outside IDLE is ignored, with no buffering.
  - amount = WIDTH-1 is the maximum; there is no wrap beyond WIDTH.
  - out_ready high while not in DONE has no effect.
  - Reset mid-ROTATE or in DONE drops the job; there is no partial output.
  - Simultaneous in_valid and reset: reset wins.
- Arithmetic: count is AMT_W bits, unsigned; no underflow is possible because it exits at count==1.

Optional Feature:
- DEROT_LOG_STEP_EN
- Defined: each ROTATE cycle rotates by the highest set bit of count (4, 2 or 1) and clears that bit. Exit when count becomes 0. Latency = popcount(amount)+1 edges (amount=0: 1 edge).
- Undefined: single-step behaviour as above.
- Port list and handshake are identical in both builds.

Decomposition:
- Package derot_pkg holds:
  - state enum (IDLE, ROTATE, DONE);
  - direction constants DIR_LEFT=1'b1, DIR_RIGHT=1'b0;
  - default WIDTH/AMT_W.
- Sub-module rot_step: combinational rotate of a WIDTH word by a one-hot step amount in a given direction. Single-step mode instantiates it with step=1; log-step mode uses a one-hot of count's MSB.

Test Plan:
- Left round trip: in_data=8'h8D (8'hB1 rotl 3), lr=1, amount=3 -> out_data=8'hB1; out_valid 4 edges after accept (macro off), 3 edges (macro on).
- Right round trip: in_data=8'h6C (8'hB1 rotr 2), lr=0, amount=2 -> out_data=8'hB1 after 3 edges (macro on: 2).
- Zero amount: in_data=8'h5A, amount=0 -> out_data=8'h5A after 1 edge, both builds.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0, second in_valid pulse ignored; out_ready=1 -> IDLE, in_ready=1 next cycle.
- Reset mid-op: amount=7 job, rst_n=0 during ROTATE -> next cycle out_valid=0, busy=0, out_data=0; after release, in_ready=1 and a fresh job completes correctly.
- Exhaustive: all 256 data × 8 amounts × 2 directions, fed via the reference rotator model -> out_data equals original for every case.
